// File: rtl/quad_array_loader.sv
// rtl/quad_array_loader.sv - assembles an N_BITS frame from a byte stream for the quadruple counter
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, k_in           begin a new frame (honoured in IDLE), target sum latched with it
//   s_valid/s_ready/s_data  input beat stream, LSB-first into array_out
//   array_out, k_out      assembled frame and its latched target sum
//   ones_count            popcount of array_out, accumulated per beat
//   frame_valid/frame_ack frame handoff to the counter stage
//   busy                  state is not IDLE
//   err_start             one-cycle pulse after a start arrives outside IDLE

module quad_array_loader #(
    parameter int N_BITS = 100,
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [7:0]                    k_in,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    output logic [N_BITS-1:0]             array_out,
    output logic [7:0]                    k_out,
    output logic [$clog2(N_BITS+1)-1:0]   ones_count,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic                          busy,
    output logic                          err_start
);

    localparam int BEATS  = (N_BITS + DATA_W - 1) / DATA_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ONES_W = $clog2(N_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [N_BITS-1:0]   array_q, array_d;
    logic [7:0]          k_q, k_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                err_start_q, err_start_d;
    logic [ONES_W-1:0]   beat_pop;
    int                  idx;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        array_d     = array_q;
        k_d         = k_q;
        ones_d      = ones_q;
        beat_pop    = '0;
        idx         = 0;
        // Any start seen while a frame is in flight is dropped but reported.
        err_start_d = start && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d     = k_in;
                    array_d = '0;
                    ones_d  = '0;
                    beat_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    // Bits past N_BITS in the final beat are neither stored nor counted.
                    for (int i = 0; i < DATA_W; i++) begin
                        idx = int'(beat_q) * DATA_W + i;
                        if (idx < N_BITS) begin
                            array_d[idx] = s_data[i];
                            beat_pop     = beat_pop + ONES_W'(s_data[i]);
                        end
                    end
                    ones_d = ones_q + beat_pop;
                    if (beat_q == LAST_BEAT) begin
                        state_d = HOLD;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            array_q     <= '0;
            k_q         <= '0;
            ones_q      <= '0;
            err_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            array_q     <= array_d;
            k_q         <= k_d;
            ones_q      <= ones_d;
            err_start_q <= err_start_d;
        end
    end

    // Handshake outputs decode straight from the state register, so they are
    // glitch-free and s_ready first rises the cycle after start.
    assign s_ready     = (state_q == LOAD);
    assign frame_valid = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign err_start   = err_start_q;
    assign array_out   = array_q;
    assign k_out       = k_q;
    assign ones_count  = ones_q;

endmodule

// File: doc/quad_array_loader.md
Name: quad_array_loader

Overview:
- Upstream input stage for the quadruple counter.
- Assembles the N_BITS-wide input bit array from a narrow valid/ready byte stream and latches the target sum k.
- Presents the completed frame, plus a running popcount, to the counter stage under a valid/ack handshake.
- Holds the frame stable until the downstream stage acknowledges it.

Parameters:
- N_BITS, 100, number of array bits per frame.
- DATA_W, 8, stream beat width. BEATS = ceil(N_BITS/DATA_W), 13 at defaults.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a new frame; honoured only in IDLE.
- k_in  in  8  target sum, sampled when start is honoured.
- s_valid  in  1  stream beat valid.
- s_data  in  DATA_W  stream beat payload.
- s_ready  out  1  loader can accept a beat.
- array_out  out  N_BITS  assembled array.
- k_out  out  8  latched k.
- ones_count  out  clog2(N_BITS+1) (7)  number of set bits in array_out.
- frame_valid  out  1  array_out/k_out/ones_count form a complete frame.
- frame_ack  in  1  downstream has consumed the frame.
- busy  out  1  state is not IDLE.
- err_start  out  1  one-cycle pulse when start arrives outside IDLE.

Behaviour:
- Reset (async assert, sync release) forces the following, from any state and mid-beat included:
  - state IDLE
  - array_out, k_out, ones_count, beat counter all 0
  - s_ready, frame_valid, busy, err_start all 0
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - s_ready=0.
  - start=1: k_out<=k_in; array_out, ones_count and beat counter cleared; next state LOAD.
  - array_out keeps its previous frame until a start is honoured.
- LOAD:
  - s_ready=1 (registered, high the cycle after start).
  - A beat is accepted when s_valid && s_ready.
  - Beat b places s_data[i] at array_out[b*DATA_W+i], LSB first.
  - Bits with index >= N_BITS in the last beat are discarded and excluded from ones_count.
  - ones_count accumulates the masked popcount of each accepted beat.
  - s_valid gaps of any length are tolerated and do not advance the beat counter.
  - Accepting beat BEATS-1 moves to HOLD, with s_ready=0 and frame_valid=1 from the next cycle.
- HOLD:
  - frame_valid=1; all frame outputs stable; s_ready=0.
  - frame_ack=1 moves to IDLE next cycle, with frame_valid=0 that cycle.
  - frame_ack is ignored outside HOLD.
- Latency: frame_valid rises exactly 1 cycle after the final beat handshake.
- start in LOAD or HOLD: ignored (no state, k or data change); err_start=1 the following cycle for one cycle.
- start and frame_ack in the same HOLD cycle: ack is honoured, start is ignored and flagged on err_start.
- start asserted the cycle after returning to IDLE is honoured normally, giving back-to-back frames with one idle cycle minimum.
- busy = (state != IDLE).
- Arithmetic:
  - ones_count is unsigned and cannot overflow, max N_BITS.
  - Beat counter is clog2(BEATS) bits and is never wrapped, since LOAD exits at BEATS-1.

Test Plan:
- Full frame: start with k_in=4, then 13 beats of 0xFF, s_valid held high -> s_ready high for 13 cycles; array_out = all 100 ones; ones_count=100; k_out=4; frame_valid rises 1 cycle after the 13th handshake.
- Bit ordering/masking: beat0=0x01, beats1-11=0x00, beat12=0xF8 -> array_out[0]=1, array_out[99]=1, all other bits 0; ones_count=2 (bits 4-7 of beat12 dropped).
- Backpressure/gaps: 13 beats of 0xA5 with s_valid toggled randomly, up to 5 idle cycles between beats -> exactly 13 accepted; ones_count = 12*4 + popcount(0x5) = 50; frame_valid timing is relative to the last handshake.
- Illegal start: start pulsed with k_in=9 after beat 3 in LOAD, and again in HOLD -> err_start one-cycle pulses; k_out stays at the original value; beat count and data unaffected; frame completes normally.
- Handshake: hold frame_ack=0 for 20 cycles in HOLD -> outputs stable. Assert frame_ack together with start -> IDLE next cycle, frame_valid=0, err_start=1. A start two cycles later is honoured.
- Reset mid-load: assert rst_n=0 asynchronously after beat 6 -> all outputs 0 immediately. Release, then run a fresh start with 13 beats of 0x0F -> ones_count=52 and no residue from the aborted frame.
